// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target.
//   sccb_state_e : protocol FSM states
//   ACK / NACK   : SDA level for acknowledge / not-acknowledge
//   RD_OOR_DATA  : byte returned for reads outside the register file
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDev,
    StAckDev,
    StAh,
    StAckAh,
    StAl,
    StAckAl,
    StWr,
    StAckWr,
    StRd,
    StRack,
    StNacked
  } sccb_state_e;

  localparam logic       ACK         = 1'b0;
  localparam logic       NACK        = 1'b1;
  localparam logic [7:0] RD_OOR_DATA = 8'hFF;

endpackage

// File: rtl/sccb_target_regs_if.sv
// Bus bundle between an SCCB master and the target.
//   scl_i, sda_i : pad inputs seen by the target
//   sda_oe       : 1 pulls SDA low (open drain)
//   wr_stb       : one-cycle pulse per committed byte, with wr_addr / wr_data
//   busy         : high from START to STOP
interface sccb_target_regs_if;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe;
  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, wr_stb, wr_addr, wr_data, busy
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe, wr_stb, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/sccb_line_filter.sv
// Conditions one bus line: 2-FF synchroniser, glitch filter, edge pulses.
//   pixclk, reset : system clock, async active-low reset
//   line_i        : raw pad level
//   level_o       : filtered level (accepted after FILT_LEN stable cycles)
//   rise_o/fall_o : one-cycle pulses on filtered transitions
module sccb_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic pixclk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      prev_q <= filt_q;
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = filt_q;
  assign rise_o  = filt_q & ~prev_q;
  assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/sccb_target_regs.sv
// SCCB target with 16-bit register pointer and 8-bit data over an internal
// register file of 2**REG_AW bytes. Lines are oversampled on pixclk.
//   pixclk, reset : system clock, async active-low reset
//   bus (slave)   : scl_i/sda_i pads, sda_oe open-drain pull, write strobe
//                   with address/data, busy flag
module sccb_target_regs
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h10,
  parameter int unsigned REG_AW   = 8,
  parameter int unsigned FILT_LEN = 3
) (
  input logic               pixclk,
  input logic               reset,
  sccb_target_regs_if.slave bus
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .pixclk (pixclk),
    .reset  (reset),
    .line_i (bus.scl_i),
    .level_o(scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .pixclk (pixclk),
    .reset  (reset),
    .line_i (bus.sda_i),
    .level_o(sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_evt, stop_evt;
  assign start_evt = sda_fall & scl_f;
  assign stop_evt  = sda_rise & scl_f;

  sccb_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] ptr_q, ptr_d;
  logic        rack_q, rack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_stb_q, wr_stb_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [7:0]  regs_q [2**REG_AW];
  logic [15:0] ptr_inc, rd_addr;
  logic [7:0]  rd_data;
  logic        ptr_in_range;

  assign ptr_inc      = ptr_q + 16'd1;
  assign ptr_in_range = (ptr_q >> REG_AW) == 16'd0;
  // In RACK the next byte to load is the one after the pointer.
  assign rd_addr      = (state_q == StRack) ? ptr_inc : ptr_q;
  assign rd_data      = ((rd_addr >> REG_AW) == 16'd0) ? regs_q[rd_addr[REG_AW-1:0]]
                                                       : RD_OOR_DATA;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    rack_d    = rack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_evt) begin
      state_d   = StDev;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_evt) begin
      state_d   = StIdle;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StDev, StAh, StAl, StWr: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = ~ACK;
            case (state_q)
              StDev: begin
                if (shreg_q[7:1] == DEV_ADDR) begin
                  state_d = StAckDev;
                end else begin
                  state_d  = StNacked;
                  sda_oe_d = 1'b0;
                end
              end
              StAh: begin
                ptr_d[15:8] = shreg_q;
                state_d     = StAckAh;
              end
              StAl: begin
                ptr_d[7:0] = shreg_q;
                state_d    = StAckAl;
              end
              default: state_d = StAckWr;
            endcase
          end
        end
        StAckDev, StAckAh, StAckAl, StAckWr: begin
          if (scl_rise && state_q == StAckWr) begin
            // Out-of-range bytes are ACKed on the bus but never committed.
            wr_stb_d = ptr_in_range;
            if (ptr_in_range) begin
              wr_addr_d = ptr_q;
              wr_data_d = shreg_q;
            end
            ptr_d = ptr_inc;
          end else if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            case (state_q)
              StAckDev: begin
                if (shreg_q[0]) begin
                  state_d  = StRd;
                  shreg_d  = rd_data;
                  sda_oe_d = ~rd_data[7];
                end else begin
                  state_d = StAh;
                end
              end
              StAckAh: state_d = StAl;
              default: state_d = StWr;
            endcase
          end
        end
        StRd: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = StRack;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            rack_d = sda_f;
          end else if (scl_fall) begin
            if (rack_q == NACK) begin
              state_d = StNacked;
            end else begin
              ptr_d     = ptr_inc;
              shreg_d   = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = 4'd0;
              state_d   = StRd;
            end
          end
        end
        StIdle, StNacked: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= 16'h0000;
      rack_q    <= NACK;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      rack_q    <= rack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file contents survive reset.
  always_ff @(posedge pixclk) begin
    if (wr_stb_d) begin
      regs_q[ptr_q[REG_AW-1:0]] <= shreg_q;
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_sccb_target_regs.sv
// Directed bench for sccb_target_regs: bit-banged SCCB master on an
// open-drain wired-AND SDA line, write-strobe monitor, immediate assertions.
module tb_sccb_target_regs;

  localparam int Q = 8;  // pixclk cycles per quarter SCL period

  logic pixclk = 1'b0;
  logic reset  = 1'b0;
  logic m_scl  = 1'b1;
  logic m_sda  = 1'b1;

  int total = 0;
  int bad   = 0;

  int          stb_cnt = 0;
  int          oe_cnt  = 0;
  logic [15:0] stb_addr[$];
  logic [7:0]  stb_data[$];

  sccb_target_regs_if bus ();

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  sccb_target_regs #(
    .DEV_ADDR(7'h10),
    .REG_AW  (8),
    .FILT_LEN(3)
  ) dut (
    .pixclk(pixclk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 pixclk = ~pixclk;

  always @(negedge pixclk) begin
    if (bus.wr_stb) begin
      stb_cnt <= stb_cnt + 1;
      stb_addr.push_back(bus.wr_addr);
      stb_data.push_back(bus.wr_data);
    end
    if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  task automatic do_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  // A glitch is a single-pixclk SCL high pulse in the middle of the setup phase.
  task automatic send_bit(input logic b, input logic glitch);
    m_sda = b;
    if (glitch) begin
      tick(Q / 2); m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q / 2 - 1);
    end else begin
      tick(Q);
    end
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = bus.sda_i; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gb, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gb);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack, 1'b0);
  endtask

  // Write n bytes (d[23:16] first) starting at register a, then STOP.
  task automatic wr_txn(input logic [15:0] a, input logic [23:0] d, input int n, input int gb,
                        output int nacks);
    logic ack;
    nacks = 0;
    do_start();
    send_byte(8'h20, -1, ack); nacks += int'(ack);
    send_byte(a[15:8], -1, ack); nacks += int'(ack);
    send_byte(a[7:0], -1, ack); nacks += int'(ack);
    for (int i = 0; i < n; i++) begin
      send_byte(d[23-8*i -: 8], gb, ack);
      nacks += int'(ack);
    end
    do_stop();
  endtask

  // Set pointer, repeated START, read n bytes (last one NACKed). No STOP.
  task automatic rd_txn(input logic [15:0] a, input int n, output logic [23:0] q,
                        output int nacks);
    logic ack;
    logic [7:0] b;
    nacks = 0;
    q = 24'h0;
    do_start();
    send_byte(8'h20, -1, ack); nacks += int'(ack);
    send_byte(a[15:8], -1, ack); nacks += int'(ack);
    send_byte(a[7:0], -1, ack); nacks += int'(ack);
    do_start();
    send_byte(8'h21, -1, ack); nacks += int'(ack);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      q[23-8*i -: 8] = b;
    end
  endtask

  initial begin
    int nacks;
    int base;
    int oe_base;
    logic ack;
    logic [23:0] q;

    // Reset values
    tick(3);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'h0);
    check("rst_wr_stb", 32'(bus.wr_stb), 32'h0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    check("rst_wr_data", 32'(bus.wr_data), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    tick(4 * Q);

    // 1: out-of-range write is ACKed but dropped, reads back FF
    base = stb_cnt;
    wr_txn(16'h3000, 24'hA50000, 1, -1, nacks);
    check("t1_nacks", 32'(nacks), 32'd0);
    check("t1_no_stb", 32'(stb_cnt - base), 32'd0);
    rd_txn(16'h3000, 1, q, nacks);
    do_stop();
    check("t1_rd_nacks", 32'(nacks), 32'd0);
    check("t1_rd_data", 32'(q[23:16]), 32'hFF);

    // 2: burst write, burst read back
    base = stb_cnt;
    wr_txn(16'h0010, 24'h112233, 3, -1, nacks);
    check("t2_nacks", 32'(nacks), 32'd0);
    check("t2_stb_cnt", 32'(stb_cnt - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t2_stb_addr", 32'(stb_addr[base+i]), 32'h10 + 32'(i));
      check("t2_stb_data", 32'(stb_data[base+i]), 32'h11 * 32'(i + 1));
    end
    rd_txn(16'h0010, 3, q, nacks);
    check("t2_rd_nacks", 32'(nacks), 32'd0);
    check("t2_rd_data", 32'(q), 32'h112233);
    tick(Q);
    check("t2_oe_after_nack", 32'(bus.sda_oe), 32'h0);
    check("t2_busy_before_stop", 32'(bus.busy), 32'h1);
    do_stop();
    tick(Q);
    check("t2_busy_after_stop", 32'(bus.busy), 32'h0);

    // 3: wrong device address
    base = stb_cnt;
    do_start();
    send_byte(8'h42, -1, ack);
    check("t3_dev_nack", 32'(ack), 32'h1);
    oe_base = oe_cnt;
    send_byte(8'h30, -1, ack);
    send_byte(8'h00, -1, ack);
    check("t3_busy", 32'(bus.busy), 32'h1);
    do_stop();
    tick(Q);
    check("t3_no_oe", 32'(oe_cnt - oe_base), 32'd0);
    check("t3_no_stb", 32'(stb_cnt - base), 32'd0);
    check("t3_busy_after", 32'(bus.busy), 32'h0);

    // 4: write crossing the end of the register file
    base = stb_cnt;
    wr_txn(16'h00FF, 24'hAABB00, 2, -1, nacks);
    check("t4_nacks", 32'(nacks), 32'd0);
    check("t4_stb_cnt", 32'(stb_cnt - base), 32'd1);
    check("t4_stb_addr", 32'(stb_addr[base]), 32'h00FF);
    check("t4_stb_data", 32'(stb_data[base]), 32'hAA);
    rd_txn(16'h0100, 1, q, nacks);
    do_stop();
    check("t4_rd_0100", 32'(q[23:16]), 32'hFF);
    rd_txn(16'h00FF, 1, q, nacks);
    do_stop();
    check("t4_rd_00ff", 32'(q[23:16]), 32'hAA);

    // 5: reset while the target drives a 0 data bit (0x11, MSB 0)
    do_start();
    send_byte(8'h20, -1, ack);
    send_byte(8'h00, -1, ack);
    send_byte(8'h10, -1, ack);
    do_start();
    send_byte(8'h21, -1, ack);
    check("t5_rd_ack", 32'(ack), 32'h0);
    check("t5_oe_driving", 32'(bus.sda_oe), 32'h1);
    reset = 1'b0;
    #1;
    check("t5_oe_async", 32'(bus.sda_oe), 32'h0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(4 * Q);
    base = stb_cnt;
    wr_txn(16'h0040, 24'h5A0000, 1, -1, nacks);
    check("t5_nacks", 32'(nacks), 32'd0);
    check("t5_stb_cnt", 32'(stb_cnt - base), 32'd1);
    check("t5_stb_addr", 32'(stb_addr[base]), 32'h0040);
    check("t5_stb_data", 32'(stb_data[base]), 32'h5A);

    // 6: one-pixclk SCL glitch inside a data byte
    base = stb_cnt;
    wr_txn(16'h0050, 24'h3C0000, 1, 3, nacks);
    check("t6_nacks", 32'(nacks), 32'd0);
    check("t6_stb_cnt", 32'(stb_cnt - base), 32'd1);
    check("t6_stb_data", 32'(stb_data[base]), 32'h3C);
    rd_txn(16'h0050, 1, q, nacks);
    do_stop();
    check("t6_rd_data", 32'(q[23:16]), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
